// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - program counter, instruction fetch handshake and instruction register
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          TIMEOUT_CYC = 16,
  parameter logic [31:0] NOP_INSTR   = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        PCEn,
  input  logic        branch,
  input  logic        btaken,
  input  logic        jal,
  input  logic        jalr,
  input  logic [31:0] imm,
  input  logic [31:0] rs1Data,
  input  logic [31:0] imem_rdata,
  input  logic        imem_rvalid,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  output logic [31:0] pc,
  output logic [31:0] pcPlus4,
  output logic [31:0] instrCode,
  output logic        instr_valid,
  output logic        fetch_busy,
  output logic        fetch_err,
  output logic        misalign_err
);

  localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  typedef enum logic [1:0] {S_REQ, S_VALID, S_ERR} state_e;

  state_e          state_q, state_d;
  logic [31:0]     pc_q, pc_d;
  logic [31:0]     instr_q, instr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [31:0]     next_pc;
  logic [31:0]     jalr_sum;
  logic [31:0]     pc_imm;
  logic            timeout_hit;
  logic            fetch_err_c;
  logic            misalign_c;

  assign pcPlus4  = pc_q + 32'd4;
  assign pc_imm   = pc_q + imm;
  assign jalr_sum = rs1Data + imm;

  always_comb begin
    if (jalr) begin
      next_pc = jalr_sum & ~32'h1;
    end else if (jal || (branch && btaken)) begin
      next_pc = pc_imm;
    end else begin
      next_pc = pcPlus4;
    end
  end

  assign timeout_hit = (TIMEOUT_CYC != 0) && (cnt_q == CW'(TIMEOUT_CYC - 1));

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    instr_d     = instr_q;
    cnt_d       = cnt_q;
    fetch_err_c = 1'b0;
    misalign_c  = 1'b0;
    case (state_q)
      S_REQ: begin
        // A response arriving in the timeout cycle still counts as a good fetch
        if (imem_rvalid) begin
          instr_d = imem_rdata;
          state_d = S_VALID;
        end else if (timeout_hit) begin
          fetch_err_c = 1'b1;
          instr_d     = NOP_INSTR;
          state_d     = S_ERR;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_VALID: begin
        if (PCEn) begin
          if (next_pc[1]) begin
            misalign_c = 1'b1;
            state_d    = S_ERR;
          end else begin
            pc_d    = next_pc;
            cnt_d   = '0;
            state_d = S_REQ;
          end
        end
      end
      S_ERR: begin
        state_d = S_ERR;
      end
      default: begin
        state_d = S_ERR;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_REQ;
      pc_q    <= RESET_PC;
      instr_q <= NOP_INSTR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Request and error pulses are held off while reset is asserted
  assign imem_req     = reset && (state_q == S_REQ);
  assign fetch_err    = reset && fetch_err_c;
  assign misalign_err = reset && misalign_c;
  assign imem_addr    = pc_q;
  assign pc           = pc_q;
  assign instrCode    = instr_q;
  assign instr_valid  = (state_q == S_VALID);
  assign fetch_busy   = (state_q != S_VALID);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - self-checking bench for instr_fetch_unit
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        PCEn = 1'b0;
  logic        branch = 1'b0;
  logic        btaken = 1'b0;
  logic        jal = 1'b0;
  logic        jalr = 1'b0;
  logic [31:0] imm = '0;
  logic [31:0] rs1Data = '0;
  logic [31:0] imem_rdata = '0;
  logic        imem_rvalid = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] pc;
  logic [31:0] pcPlus4;
  logic [31:0] instrCode;
  logic        instr_valid;
  logic        fetch_busy;
  logic        fetch_err;
  logic        misalign_err;

  instr_fetch_unit #(
    .RESET_PC(32'h0000_0000),
    .TIMEOUT_CYC(16),
    .NOP_INSTR(32'h0000_0013)
  ) dut (
    .clk(clk), .reset(reset), .PCEn(PCEn), .branch(branch), .btaken(btaken),
    .jal(jal), .jalr(jalr), .imm(imm), .rs1Data(rs1Data),
    .imem_rdata(imem_rdata), .imem_rvalid(imem_rvalid),
    .imem_req(imem_req), .imem_addr(imem_addr), .pc(pc), .pcPlus4(pcPlus4),
    .instrCode(instrCode), .instr_valid(instr_valid), .fetch_busy(fetch_busy),
    .fetch_err(fetch_err), .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_instr_q[$];
  logic [31:0] cur_pc;
  bit          mem_on = 1'b1;
  int          mem_wait = 0;
  int          wcnt = 0;
  logic        req_n, rv_n, rst_n_s, req_prev, val_prev;
  logic [31:0] addr_n;

  typedef struct {
    logic        br, bt, j, jr;
    logic [31:0] imm, rs1, exp_pc;
  } vec_t;
  vec_t vecs[12];

  function automatic logic [31:0] memf(input logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    return {a[19:0], 12'h0B3};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory model: one registered cycle plus mem_wait extra cycles per request
  always @(negedge clk) begin
    req_n   = imem_req;
    rv_n    = imem_rvalid;
    addr_n  = imem_addr;
    rst_n_s = reset;
  end

  always @(posedge clk) begin
    #1;
    imem_rvalid = 1'b0;
    if (!rst_n_s) begin
      wcnt = 0;
    end else if (mem_on && req_n && !rv_n) begin
      if (wcnt >= mem_wait) begin
        imem_rvalid = 1'b1;
        imem_rdata  = memf(addr_n);
        wcnt        = 0;
      end else begin
        wcnt++;
      end
    end
  end

  // Scoreboard: every fetch start and every newly valid instruction is matched
  always @(negedge clk) begin
    if (imem_req && !req_prev) begin
      if (exp_addr_q.size() == 0) chk("unexpected_fetch", imem_addr, 32'hDEAD_BEEF);
      else chk("fetch_addr", imem_addr, exp_addr_q.pop_front());
    end
    if (instr_valid && !val_prev) begin
      if (exp_instr_q.size() == 0) chk("unexpected_valid", instrCode, 32'hDEAD_BEEF);
      else chk("instrCode", instrCode, exp_instr_q.pop_front());
    end
    req_prev = imem_req;
    val_prev = instr_valid;
  end

  task automatic reset_dut(input bit seq);
    @(posedge clk); #1;
    reset = 1'b0; PCEn = 1'b0; mem_wait = 0;
    exp_addr_q.delete();
    exp_instr_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_pc", pc, 32'h0);
    chk("rst_instr", instrCode, 32'h0000_0013);
    chk("rst_valid", instr_valid, 0);
    chk("rst_req", imem_req, 0);
    chk("rst_errs", {fetch_err, misalign_err}, 0);
    @(posedge clk); #1;
    exp_addr_q.push_back(32'h0);
    exp_instr_q.push_back(memf(32'h0));
    cur_pc = 32'h0;
    reset  = 1'b1;
    if (seq) begin
      @(negedge clk);
      chk("c1_req", imem_req, 1);
      chk("c1_addr", imem_addr, 32'h0);
      @(negedge clk);
      chk("c2_valid", instr_valid, 0);
      @(negedge clk);
      chk("c3_valid", instr_valid, 1);
      chk("c3_instr", instrCode, 32'h0050_0093);
      chk("c3_pc", pc, 32'h0);
    end
  endtask

  task automatic wait_valid();
    int n = 0;
    @(negedge clk);
    while (!instr_valid && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("wait_valid", instr_valid, 1);
  endtask

  task automatic apply_vec(input vec_t v, input int idx);
    wait_valid();
    chk($sformatf("v%0d_pc_before", idx), pc, cur_pc);
    @(posedge clk); #1;
    mem_wait = $urandom_range(0, 3);
    branch = v.br; btaken = v.bt; jal = v.j; jalr = v.jr;
    imm = v.imm; rs1Data = v.rs1; PCEn = 1'b1;
    exp_addr_q.push_back(v.exp_pc);
    exp_instr_q.push_back(memf(v.exp_pc));
    @(negedge clk);
    chk($sformatf("v%0d_misalign", idx), misalign_err, 0);
    @(posedge clk); #1;
    PCEn = 1'b0; branch = 1'b0; btaken = 1'b0; jal = 1'b0; jalr = 1'b0;
    imm = '0; rs1Data = '0;
    @(negedge clk);
    chk($sformatf("v%0d_valid_drop", idx), instr_valid, 0);
    chk($sformatf("v%0d_pc", idx), pc, v.exp_pc);
    cur_pc = v.exp_pc;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //         br    bt    jal   jalr  imm            rs1            exp_pc
    vecs[0]  = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h10,        32'h0,         32'h10};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         32'h0,         32'h14};
    vecs[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, 32'hC,         32'h0,         32'h20};
    vecs[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFF8, 32'h0,         32'h18};
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h8,         32'h0,         32'h20};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFF8, 32'h0,         32'h24};
    vecs[6]  = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h4,         32'h101,       32'h104};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h20,        32'hFFFF_FFF0, 32'h10};
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFF0, 32'h0,         32'h0};
    vecs[9]  = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h8,         32'h200,       32'h208};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         32'h0,         32'h20C};
    vecs[11] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'hFFFF_FE34, 32'h0,         32'h40};

    req_prev = 1'b0;
    val_prev = 1'b0;
    reset_dut(1'b1);
    for (int i = 0; i < 12; i++) apply_vec(vecs[i], i);

    // Reset while a fetch is outstanding restarts from RESET_PC
    wait_valid();
    @(posedge clk); #1;
    mem_on = 1'b0; PCEn = 1'b1;
    exp_addr_q.push_back(32'h44);
    @(posedge clk); #1;
    PCEn = 1'b0;
    repeat (4) @(negedge clk);
    chk("midwait_pc", pc, 32'h44);
    chk("midwait_req", imem_req, 1);
    mem_on = 1'b1;
    reset_dut(1'b1);

    // Misaligned jal target
    apply_vec('{1'b0, 1'b0, 1'b1, 1'b0, 32'h40, 32'h0, 32'h40}, 12);
    wait_valid();
    @(posedge clk); #1;
    jal = 1'b1; imm = 32'h2; PCEn = 1'b1;
    @(negedge clk);
    chk("mis_pulse", misalign_err, 1);
    @(posedge clk); #1;
    jal = 1'b0; imm = '0; PCEn = 1'b0;
    @(negedge clk);
    chk("mis_once", misalign_err, 0);
    chk("mis_pc", pc, 32'h40);
    chk("mis_busy", fetch_busy, 1);
    chk("mis_valid", instr_valid, 0);
    @(posedge clk); #1;
    PCEn = 1'b1;
    @(posedge clk); #1;
    PCEn = 1'b0;
    @(negedge clk);
    chk("err_pcen_pc", pc, 32'h40);
    chk("err_pcen_req", imem_req, 0);

    // Fetch timeout with a silent memory
    mem_on = 1'b0;
    reset_dut(1'b0);
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      chk($sformatf("to_err_c%0d", i), fetch_err, (i == 16) ? 32'd1 : 32'd0);
    end
    @(negedge clk);
    chk("to_err_once", fetch_err, 0);
    chk("to_instr_nop", instrCode, 32'h0000_0013);
    chk("to_busy", fetch_busy, 1);
    chk("to_req", imem_req, 0);
    repeat (5) @(negedge clk);
    chk("to_hold_valid", instr_valid, 0);
    chk("to_hold_req", imem_req, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Upstream neighbour of the multi-cycle control unit. Owns the program counter and the instruction register.
- Fetches each instruction from instruction memory over a req/rvalid handshake and holds it stable on instrCode for the FSM.
- Computes and commits the next PC (sequential, branch, jal, jalr) when the control unit pulses PCEn.
- Reports fetch timeouts and misaligned targets, then halts.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- TIMEOUT_CYC, 16, maximum cycles waiting for imem_rvalid; 0 disables the timeout.
- NOP_INSTR, 32'h0000_0013, instrCode value after reset and after an error.

Ports:
- clk  input  1  system clock, all state updates on posedge
- reset  input  1  synchronous, active-low reset; sampled at posedge clk, 0 = reset
- PCEn  input  1  one-cycle pulse from control unit: commit next PC, start new fetch
- branch  input  1  current instruction is a B-type
- btaken  input  1  ALU branch comparison result
- jal  input  1  current instruction is jal or jalr
- jalr  input  1  current instruction is jalr
- imm  input  32  sign-extended immediate of current instruction
- rs1Data  input  32  register-file rs1 read data
- imem_rdata  input  32  instruction memory read data
- imem_rvalid  input  1  imem_rdata valid this cycle
- imem_req  output  1  fetch request, held until imem_rvalid
- imem_addr  output  32  fetch address (= pc while imem_req)
- pc  output  32  current PC
- pcPlus4  output  32  pc + 4, combinational
- instrCode  output  32  instruction register
- instr_valid  output  1  instrCode holds the instruction at pc
- fetch_busy  output  1  high whenever state != S_VALID
- fetch_err  output  1  one-cycle pulse on timeout
- misalign_err  output  1  one-cycle pulse on misaligned target

Behaviour:
- Reset (reset==0 at posedge):
  - State goes to S_REQ; pc=RESET_PC; instrCode=NOP_INSTR.
  - instr_valid=0, imem_req=0, fetch_err=0, misalign_err=0, timeout counter=0.
  - Reset wins over every other event, including mid-fetch.
  - After reset: imem_req rises in the first cycle with reset==1.
- States: S_REQ, S_VALID, S_ERR.
- S_REQ:
  - imem_req=1, imem_addr=pc.
  - On imem_rvalid: instrCode<=imem_rdata, next state S_VALID. Latency: instr_valid is high the cycle after rvalid is sampled. Zero-wait memory gives 2 cycles from imem_req rise to instr_valid.
  - Otherwise the counter increments. If TIMEOUT_CYC!=0 and counter reaches TIMEOUT_CYC-1 with no rvalid: fetch_err pulses for 1 cycle, instrCode<=NOP_INSTR, next state S_ERR.
  - rvalid and the timeout in the same cycle: rvalid wins.
- S_VALID:
  - instr_valid=1, imem_req=0; instrCode and pc held stable.
  - On PCEn, next-PC priority:
    - jalr: (rs1Data+imm) & ~32'h1
    - else jal: pc+imm
    - else branch & btaken: pc+imm
    - else pc+4
    - All adds are modulo 2^32; wrap-around is silent.
  - If next-PC[1]==1: pc unchanged, misalign_err pulses for 1 cycle, next state S_ERR.
  - Otherwise: pc<=next-PC, counter<=0, next state S_REQ; instr_valid drops the next cycle.
- S_ERR: imem_req=0, instr_valid=0, fetch_busy=1. Held until reset.
- PCEn outside S_VALID: ignored, with no PC change.
- imem_rvalid outside S_REQ: ignored.
- imem_rdata is sampled only on rvalid in S_REQ.
- branch and jal inputs are sampled only in the PCEn cycle.

Test Plan:
- Reset release, memory returns 0x00500093 after 0 waits -> imem_req=1, imem_addr=0 in cycle 1; instr_valid=1, instrCode=0x00500093 in cycle 3; pc=0.
- In S_VALID at pc=0x10, PCEn with no branch/jal -> pc=0x14, imem_addr=0x14, instr_valid low for at least 1 cycle.
- pc=0x20, branch=1, btaken=1, imm=-8 -> pc=0x18; same stimulus with btaken=0 -> pc=0x24.
- jalr=1, jal=1, rs1Data=0x101, imm=4 -> pc=0x104 (bit0 cleared).
- jal=1, imm=0x2 at pc=0x40 -> misalign_err pulses once, pc stays 0x40, fetch_busy=1, and later PCEn is ignored.
- TIMEOUT_CYC=16, memory never responds -> fetch_err pulses at the 16th req cycle, instrCode=0x00000013, S_ERR held. Asserting reset=0 mid-wait instead gives pc=RESET_PC and restarts the fetch.
